// File: rtl/psg_bus_arbiter.sv
// psg_bus_arbiter: round-robin arbiter that serialises two requesters onto a PSG register bus
//   clk, rst_n                       : clock, asynchronous active-low reset
//   reqN_valid/we/addr/wdata         : request handshake and payload from requester N
//   reqN_ready                       : combinational accept strobe (IDLE only)
//   reqN_rvalid/rdata                : one-cycle read strobe and held read data
//   psg_addr/din/cs_n/wr_n, psg_dout : PSG register bus
//   busy, grant_id                   : access in progress, owner of current/last access
module psg_bus_arbiter #(
    parameter int WR_CYCLES  = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic       req0_we,
    input  logic       req1_we,
    input  logic [3:0] req0_addr,
    input  logic [3:0] req1_addr,
    input  logic [7:0] req0_wdata,
    input  logic [7:0] req1_wdata,
    output logic       req0_rvalid,
    output logic       req1_rvalid,
    output logic [7:0] req0_rdata,
    output logic [7:0] req1_rdata,
    output logic [3:0] psg_addr,
    output logic [7:0] psg_din,
    output logic       psg_cs_n,
    output logic       psg_wr_n,
    input  logic [7:0] psg_dout,
    output logic       busy,
    output logic       grant_id
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, READ, GAP} state_t;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       we_q, we_d, rr_q, rr_d, gid_d;
    logic [3:0] addr_d;
    logic [7:0] din_d, rd0_d, rd1_d;
    logic       cs_n_d, wr_n_d, busy_d, rv0_d, rv1_d;
    logic       accept, gnt, last_rd;
    // rr_q names the requester that wins the next tie
    assign gnt        = (req0_valid & req1_valid) ? rr_q : req1_valid;
    assign accept     = rst_n & (state_q == IDLE) & (req0_valid | req1_valid);
    assign req0_ready = accept & ~gnt;
    assign req1_ready = accept & gnt;
    assign last_rd    = (state_q == READ) && (cnt_q == 4'd0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // cnt_q holds the remaining cycles of the timed states, counting down to 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:        state_d = accept ? SETUP : IDLE;
            SETUP: begin
                state_d = we_q ? STROBE : READ;
                cnt_d   = we_q ? 4'(WR_CYCLES - 1) : 4'd1;
            end
            STROBE, READ: begin
                state_d = (cnt_q == 4'd0) ? GAP : state_q;
                cnt_d   = (cnt_q == 4'd0) ? 4'(GAP_CYCLES - 1) : cnt_q - 4'd1;
            end
            GAP: begin
                state_d = (cnt_q == 4'd0) ? IDLE : GAP;
                cnt_d   = cnt_q - 4'd1;
            end
            default:     state_d = IDLE;
        endcase
    end
    // bus outputs are registered from the next state so they line up with state_q
    always_comb begin
        cs_n_d = !(state_d inside {SETUP, STROBE, READ});
        wr_n_d = state_d != STROBE;
        busy_d = state_d != IDLE;
        rv0_d  = last_rd & ~grant_id;
        rv1_d  = last_rd & grant_id;
        rd0_d  = rv0_d ? psg_dout : req0_rdata;
        rd1_d  = rv1_d ? psg_dout : req1_rdata;
        addr_d = accept ? (gnt ? req1_addr : req0_addr) : psg_addr;
        din_d  = accept ? (gnt ? req1_wdata : req0_wdata) : psg_din;
        we_d   = accept ? (gnt ? req1_we : req0_we) : we_q;
        gid_d  = accept ? gnt : grant_id;
        rr_d   = accept ? ~gnt : rr_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psg_cs_n    <= 1'b1;
            psg_wr_n    <= 1'b1;
            psg_addr    <= '0;
            psg_din     <= '0;
            busy        <= 1'b0;
            grant_id    <= 1'b0;
            rr_q        <= 1'b0;
            we_q        <= 1'b0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            psg_cs_n    <= cs_n_d;
            psg_wr_n    <= wr_n_d;
            psg_addr    <= addr_d;
            psg_din     <= din_d;
            busy        <= busy_d;
            grant_id    <= gid_d;
            rr_q        <= rr_d;
            we_q        <= we_d;
            req0_rvalid <= rv0_d;
            req1_rvalid <= rv1_d;
            req0_rdata  <= rd0_d;
            req1_rdata  <= rd1_d;
        end
    end
endmodule

// File: tb/tb_psg_bus_arbiter.sv
// tb_psg_bus_arbiter: directed self-checking bench for psg_bus_arbiter
module tb_psg_bus_arbiter;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0, req0_we = 1'b0, req1_we = 1'b0;
    logic [3:0] req0_addr = '0, req1_addr = '0;
    logic [7:0] req0_wdata = '0, req1_wdata = '0, psg_dout = '0;
    logic       req0_ready, req1_ready, req0_rvalid, req1_rvalid;
    logic [7:0] req0_rdata, req1_rdata, psg_din;
    logic [3:0] psg_addr;
    logic       psg_cs_n, psg_wr_n, busy, grant_id;
    logic       l_valid = 1'b0;
    logic       l_ready, l1_ready, l_rvalid, l1_rvalid, l_cs_n, l_wr_n, l_busy, l_gid;
    logic [7:0] l_rdata, l1_rdata, l_din;
    logic [3:0] l_addr;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    psg_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_we(req0_we), .req1_we(req1_we),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .req0_rvalid(req0_rvalid), .req1_rvalid(req1_rvalid),
        .req0_rdata(req0_rdata), .req1_rdata(req1_rdata),
        .psg_addr(psg_addr), .psg_din(psg_din), .psg_cs_n(psg_cs_n), .psg_wr_n(psg_wr_n),
        .psg_dout(psg_dout), .busy(busy), .grant_id(grant_id)
    );

    psg_bus_arbiter #(.WR_CYCLES(4), .GAP_CYCLES(3)) dut_long (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(l_valid), .req1_valid(1'b0),
        .req0_ready(l_ready), .req1_ready(l1_ready),
        .req0_we(1'b1), .req1_we(1'b0),
        .req0_addr(4'd13), .req1_addr(4'd0),
        .req0_wdata(8'hC3), .req1_wdata(8'h00),
        .req0_rvalid(l_rvalid), .req1_rvalid(l1_rvalid),
        .req0_rdata(l_rdata), .req1_rdata(l1_rdata),
        .psg_addr(l_addr), .psg_din(l_din), .psg_cs_n(l_cs_n), .psg_wr_n(l_wr_n),
        .psg_dout(8'h00), .busy(l_busy), .grant_id(l_gid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready got=%b%b want=00", req0_ready, req1_ready);
        end
        tick();
        total++;
        if ({psg_cs_n, psg_wr_n, psg_addr, psg_din, req0_rvalid, req1_rvalid, req0_rdata, req1_rdata, busy, grant_id}
            !== {1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state cs_n=%b wr_n=%b addr=%h din=%h rv=%b%b rd=%h/%h busy=%b gid=%b want 1 1 0 00 00 00/00 0 0",
                     psg_cs_n, psg_wr_n, psg_addr, psg_din, req0_rvalid, req1_rvalid, req0_rdata, req1_rdata, busy, grant_id);
        end
        total++;
        if ({l_cs_n, l_wr_n, l_busy, l_ready} !== 4'b1100) begin
            bad++;
            $display("FAIL reset_long cs_n=%b wr_n=%b busy=%b ready=%b want 1 1 0 0", l_cs_n, l_wr_n, l_busy, l_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        l_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'd8; req0_wdata = 8'h0F;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL wr_accept ready=%b%b want=10", req0_ready, req1_ready);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                total++;
                if (req0_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL wr_ready_busy got=%b want=0", req0_ready);
                end
                req0_valid = 1'b0;
            end
            total++;
            if ({psg_cs_n, psg_wr_n, busy} !== {(k < 1 || k > 3), !(k == 2 || k == 3), k <= 4}) begin
                bad++;
                $display("FAIL wr_seq k=%0d cs_n=%b wr_n=%b busy=%b want %b %b %b", k, psg_cs_n, psg_wr_n, busy,
                         (k < 1 || k > 3), !(k == 2 || k == 3), k <= 4);
            end
            if (k <= 4) begin
                total++;
                if ({psg_addr, psg_din, grant_id} !== {4'd8, 8'h0F, 1'b0}) begin
                    bad++;
                    $display("FAIL wr_bus k=%0d addr=%h din=%h gid=%b want 8 0f 0", k, psg_addr, psg_din, grant_id);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int  g = 0;
        logic seen = 1'b0;
        logic id = 1'b0;
        test_reset();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'd1; req0_wdata = 8'h11;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 4'd2; req1_wdata = 8'h22;
        for (int c = 0; c < 40 && g < 4; c++) begin
            #1;
            if (seen) begin
                total++;
                if (grant_id !== id) begin
                    bad++;
                    $display("FAIL rr_grant_id got=%b want=%b", grant_id, id);
                end
                seen = 1'b0;
            end
            if (req0_ready | req1_ready) begin
                total++;
                if ({req0_ready, req1_ready} !== ((g % 2 == 0) ? 2'b10 : 2'b01)) begin
                    bad++;
                    $display("FAIL rr_order n=%0d ready=%b%b want=%b", g, req0_ready, req1_ready,
                             (g % 2 == 0) ? 2'b10 : 2'b01);
                end
                seen = 1'b1;
                id = req1_ready;
                g++;
            end
            @(posedge clk);
        end
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        total++;
        if (g < 4 || grant_id !== 1'b1) begin
            bad++;
            $display("FAIL rr_count grants=%0d gid=%b want 4 1", g, grant_id);
        end
        for (int c = 0; c < 20 && busy; c++) tick();
    endtask

    task automatic test_read();
        test_reset();
        psg_dout = 8'h11;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'd7;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++;
            $display("FAIL rd_accept ready=%b%b want=01", req0_ready, req1_ready);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) req1_valid = 1'b0;
            psg_dout = (k == 3) ? 8'h3F : 8'h22;
            total++;
            if ({req1_rvalid, req1_rdata, req0_rvalid, req0_rdata, psg_cs_n, psg_wr_n}
                !== {k == 4, (k >= 4) ? 8'h3F : 8'h00, 1'b0, 8'h00, (k < 1 || k > 3), 1'b1}) begin
                bad++;
                $display("FAIL rd1_seq k=%0d rv1=%b rd1=%h rv0=%b rd0=%h cs_n=%b wr_n=%b want %b %h 0 00 %b 1", k,
                         req1_rvalid, req1_rdata, req0_rvalid, req0_rdata, psg_cs_n, psg_wr_n,
                         k == 4, (k >= 4) ? 8'h3F : 8'h00, (k < 1 || k > 3));
            end
        end
        psg_dout = 8'hA5;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'd5;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL rd0_accept ready=%b%b want=10", req0_ready, req1_ready);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) req0_valid = 1'b0;
            total++;
            if ({req0_rvalid, req0_rdata, req1_rvalid, req1_rdata}
                !== {k == 4, (k >= 4) ? 8'hA5 : 8'h00, 1'b0, 8'h3F}) begin
                bad++;
                $display("FAIL rd0_seq k=%0d rv0=%b rd0=%h rv1=%b rd1=%h want %b %h 0 3f", k,
                         req0_rvalid, req0_rdata, req1_rvalid, req1_rdata, k == 4, (k >= 4) ? 8'hA5 : 8'h00);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_reset();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'd13; req0_wdata = 8'h55;
        #1;
        total++;
        if (req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept ready=%b want=1", req0_ready);
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            total++;
            if ({req0_ready, psg_cs_n, psg_wr_n} !== {k == 5, !(k inside {1, 2, 3, 6, 7, 8}), !(k inside {2, 3, 7, 8})}) begin
                bad++;
                $display("FAIL b2b_seq k=%0d ready=%b cs_n=%b wr_n=%b want %b %b %b", k, req0_ready, psg_cs_n, psg_wr_n,
                         k == 5, !(k inside {1, 2, 3, 6, 7, 8}), !(k inside {2, 3, 7, 8}));
            end
            if (k == 6) req0_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        test_reset();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'd3; req0_wdata = 8'h09;
        tick();
        tick();
        total++;
        if ({psg_cs_n, psg_wr_n} !== 2'b00) begin
            bad++;
            $display("FAIL mid_strobe cs_n=%b wr_n=%b want 0 0", psg_cs_n, psg_wr_n);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({psg_cs_n, psg_wr_n, busy, req0_ready} !== 4'b1100) begin
            bad++;
            $display("FAIL mid_abort cs_n=%b wr_n=%b busy=%b ready=%b want 1 1 0 0", psg_cs_n, psg_wr_n, busy, req0_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({req0_rvalid, req1_rvalid, psg_wr_n} !== 3'b001) begin
                bad++;
                $display("FAIL mid_quiet rv=%b%b wr_n=%b want 00 1", req0_rvalid, req1_rvalid, psg_wr_n);
            end
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reaccept ready=%b want=1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        total++;
        if ({psg_cs_n, psg_wr_n, busy, psg_addr} !== {1'b0, 1'b1, 1'b1, 4'd3}) begin
            bad++;
            $display("FAIL mid_setup cs_n=%b wr_n=%b busy=%b addr=%h want 0 1 1 3", psg_cs_n, psg_wr_n, busy, psg_addr);
        end
        for (int c = 0; c < 20 && busy; c++) tick();
    endtask

    task automatic test_long_params();
        test_reset();
        l_valid = 1'b1;
        #1;
        total++;
        if (l_ready !== 1'b1) begin
            bad++;
            $display("FAIL long_accept ready=%b want=1", l_ready);
        end
        for (int k = 1; k <= 18; k++) begin
            int kk;
            kk = ((k - 1) % 9) + 1;
            tick();
            total++;
            if ({l_ready, l_cs_n, l_wr_n} !== {kk == 9, kk > 5, !(kk >= 2 && kk <= 5)}) begin
                bad++;
                $display("FAIL long_seq k=%0d ready=%b cs_n=%b wr_n=%b want %b %b %b", k, l_ready, l_cs_n, l_wr_n,
                         kk == 9, kk > 5, !(kk >= 2 && kk <= 5));
            end
        end
        tick();
        l_valid = 1'b0;
        for (int c = 0; c < 20 && l_busy; c++) tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_simultaneous();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_long_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/psg_bus_arbiter.md
PSG_BUS_ARBITER -- requirements
Module: psg_bus_arbiter

Interface
REQ-001 SHALL have parameter WR_CYCLES, default 2: cycles psg_wr_n is held low per write; legal range 1..15.
REQ-002 SHALL have parameter GAP_CYCLES, default 1: idle cycles with psg_cs_n=psg_wr_n=1 after every access; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  access request pending.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-007 SHALL have ports req0_we / req1_we  input  1  1=write, 0=read.
REQ-008 SHALL have ports req0_addr / req1_addr  input  4  PSG register index.
REQ-009 SHALL have ports req0_wdata / req1_wdata  input  8  write data.
REQ-010 SHALL have ports req0_rvalid / req1_rvalid  output  1  one-cycle read-data strobe.
REQ-011 SHALL have ports req0_rdata / req1_rdata  output  8  read data, held until next read completes for that requester.
REQ-012 SHALL have ports psg_addr  output  4,  psg_din  output  8,  psg_cs_n  output  1,  psg_wr_n  output  1  PSG register bus.
REQ-013 SHALL have port psg_dout  input  8  PSG registered read data.
REQ-014 SHALL have ports busy  output  1  (state not IDLE) and grant_id  output  1  (requester owning current/last access).

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, STROBE, READ, GAP; all outputs registered except reqN_ready.
REQ-016 IDLE: if any valid, SHALL grant one requester, assert its reqN_ready combinationally that cycle, latch we/addr/wdata/id, and go to SETUP.
REQ-017 Both valid in IDLE: SHALL grant the requester not granted last (round-robin); single valid always wins.
REQ-018 reqN_ready SHALL be 0 in every non-IDLE state; requester holds valid and payload until ready.
REQ-019 SETUP (1 cycle): psg_addr/psg_din = latched values, psg_cs_n=0, psg_wr_n=1; next STROBE if write, READ if read.
REQ-020 STROBE: psg_cs_n=0, psg_wr_n=0 for exactly WR_CYCLES cycles, address/data stable; then GAP.
REQ-021 READ: psg_cs_n=0, psg_wr_n=1 for 2 cycles; on the last READ cycle SHALL capture psg_dout into granted reqN_rdata and pulse reqN_rvalid for 1 cycle in the following cycle; then GAP.
REQ-022 GAP: psg_cs_n=1, psg_wr_n=1 for GAP_CYCLES cycles, psg_addr/psg_din keep last value; then IDLE.
REQ-023 Write occupancy SHALL be 1+WR_CYCLES+GAP_CYCLES cycles after the accept cycle; read occupancy 1+2+GAP_CYCLES.
REQ-024 psg_wr_n SHALL return high between any two consecutive writes (guaranteed by GAP>=1), so back-to-back writes to register 13 each produce a write edge.
REQ-025 grant_id SHALL update in the cycle after acceptance and hold through GAP.
REQ-026 The non-granted requester's rvalid SHALL stay 0 and its rdata SHALL not change.
REQ-027 Round-robin pointer SHALL update only on acceptance.

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, psg_cs_n=1, psg_wr_n=1, psg_addr=0, psg_din=0, req0/1_rvalid=0, req0/1_rdata=0, busy=0, grant_id=0, round-robin pointer so requester 0 wins first tie.
REQ-029 Reset mid-access SHALL abort it: no rvalid pulse, strobe terminated immediately, operation not retried.
REQ-030 reqN_ready SHALL be 0 while rst_n is low.

Verification
REQ-031 Single write: req0 write addr 8, data 0x0F, defaults -> ready at T, cs_n low T+1..T+3, wr_n low T+2..T+3, din=0x0F, IDLE at T+5.
REQ-032 Simultaneous: both valid after reset -> req0 granted first, req1 next; both held valid -> grants alternate 0,1,0,1.
REQ-033 Read: req1 reads addr 7 with psg_dout=0x3F -> req1_rvalid single pulse at T+4, req1_rdata=0x3F, req0_rvalid stays 0.
REQ-034 Back-to-back req0 writes to addr 13 -> two separate wr_n low pulses separated by >=1 cycle with wr_n=1 and cs_n=1.
REQ-035 rst_n asserted during STROBE -> psg_wr_n and psg_cs_n high in the same cycle, busy=0, no rvalid, next request accepted normally after release.
REQ-036 WR_CYCLES=4, GAP_CYCLES=3 -> wr_n low exactly 4 cycles, gap exactly 3 cycles, ready-to-ready spacing 9 cycles for continuous writes.
